read_return_demux: RTL and testbench

Return-path demultiplexer for the two-master unidirectional bus into the SDRAM controller. A request-side 2:1 mux forwards one master's read onto the shared bus; this block records which master issued each read in an in-order tag FIFO. When SDRAM read data comes back, it pops the oldest tag and steers the data to the matching master's registered output port. It is the return path that pairs with the request mux and sits between the SDRAM controller read-data output and the two masters.

---
 rtl/read_return_demux_pkg.sv | 20 ++
 rtl/read_return_demux_tag_fifo.sv | 70 +++++++
 rtl/read_return_demux.sv | 106 ++++++++++
 tb/tb_read_return_demux.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/read_return_demux_pkg.sv
// Shared constants for the two-master SDRAM read path: master select encoding,
// default tag FIFO depth and pointer/count width helpers.
package read_return_demux_pkg;

   // Request mux Sel encoding, shared with the request side.
   localparam logic MASTER1_SEL = 1'b1;
   localparam logic MASTER2_SEL = 1'b0;

   localparam int DEFAULT_DEPTH = 4;

   function automatic int ptr_w(input int depth);
      return $clog2(depth);
   endfunction

   // Count must represent 0..depth inclusive.
   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/read_return_demux_tag_fifo.sv
// In-order 1-bit tag FIFO recording which master issued each outstanding read.
// Pushes into a full FIFO and pops from an empty one are ignored.
module tag_fifo
   import read_return_demux_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    push,
   input  logic                    push_tag,
   input  logic                    pop,
   output logic                    head_tag,
   output logic [cnt_w(DEPTH)-1:0] count,
   output logic                    full,
   output logic                    empty
);

   localparam int PTR_W = ptr_w(DEPTH);
   localparam int CNT_W = cnt_w(DEPTH);

   logic [DEPTH-1:0] mem_q, mem_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             do_push, do_pop;

   assign full     = (cnt_q == CNT_W'(DEPTH));
   assign empty    = (cnt_q == '0);
   assign count    = cnt_q;
   assign head_tag = mem_q[rd_ptr_q];

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = push_tag;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: rtl/read_return_demux.sv
// Return-path demux: steers SDRAM read data to the master that issued the read.
// Define READ_RETURN_ERRCHK_EN to build the sticky protocol-error flag.
module read_return_demux
   import read_return_demux_pkg::*;
#(
   parameter int BITWIDTH = 8,
   parameter int DEPTH    = DEFAULT_DEPTH
) (
   input  logic                    Clk,
   input  logic                    Rst_n,
   input  logic                    ReqValid,
   input  logic                    ReqSel,
   output logic                    ReqReady,
   input  logic                    RdValid,
   input  logic [BITWIDTH-1:0]     RdData,
   output logic                    Out1Valid,
   output logic [BITWIDTH-1:0]     Out1Data,
   output logic                    Out2Valid,
   output logic [BITWIDTH-1:0]     Out2Data,
   output logic [cnt_w(DEPTH)-1:0] Outstanding,
   output logic                    Error
);

   logic                    req_push;
   logic                    rd_pop;
   logic                    head_tag;
   logic                    fifo_full;
   logic                    fifo_empty;
   logic [cnt_w(DEPTH)-1:0] fifo_count;

   logic                    out1_valid_q, out1_valid_d;
   logic [BITWIDTH-1:0]     out1_data_q, out1_data_d;
   logic                    out2_valid_q, out2_valid_d;
   logic [BITWIDTH-1:0]     out2_data_q, out2_data_d;

   // Ready depends only on occupancy, so there is no ReqValid -> ReqReady path.
   assign ReqReady = !fifo_full;
   assign req_push = ReqValid && ReqReady;
   assign rd_pop   = RdValid && !fifo_empty;

   tag_fifo #(
      .DEPTH(DEPTH)
   ) u_tag_fifo (
      .clk     (Clk),
      .rst_n   (Rst_n),
      .push    (req_push),
      .push_tag(ReqSel),
      .pop     (rd_pop),
      .head_tag(head_tag),
      .count   (fifo_count),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign Outstanding = fifo_count;

   always_comb begin
      out1_valid_d = rd_pop && (head_tag == MASTER1_SEL);
      out2_valid_d = rd_pop && (head_tag == MASTER2_SEL);
      out1_data_d  = out1_valid_d ? RdData : out1_data_q;
      out2_data_d  = out2_valid_d ? RdData : out2_data_q;
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         out1_valid_q <= 1'b0;
         out1_data_q  <= '0;
         out2_valid_q <= 1'b0;
         out2_data_q  <= '0;
      end else begin
         out1_valid_q <= out1_valid_d;
         out1_data_q  <= out1_data_d;
         out2_valid_q <= out2_valid_d;
         out2_data_q  <= out2_data_d;
      end
   end

   assign Out1Valid = out1_valid_q;
   assign Out1Data  = out1_data_q;
   assign Out2Valid = out2_valid_q;
   assign Out2Data  = out2_data_q;

`ifdef READ_RETURN_ERRCHK_EN
   logic error_q, error_d;

   // Sticky: overflow (request while not ready) or underflow (data while empty).
   always_comb begin
      error_d = error_q
              | (ReqValid && !ReqReady)
              | (RdValid && fifo_empty);
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         error_q <= 1'b0;
      end else begin
         error_q <= error_d;
      end
   end

   assign Error = error_q;
`else
   assign Error = 1'b0;
`endif

endmodule

// File: tb/tb_read_return_demux.sv
// Directed self-checking bench for read_return_demux (BITWIDTH=8, DEPTH=4).
module tb_read_return_demux;

   logic       Clk = 1'b0;
   logic       Rst_n = 1'b1;
   logic       ReqValid = 1'b0;
   logic       ReqSel = 1'b0;
   logic       ReqReady;
   logic       RdValid = 1'b0;
   logic [7:0] RdData = 8'h00;
   logic       Out1Valid;
   logic [7:0] Out1Data;
   logic       Out2Valid;
   logic [7:0] Out2Data;
   logic [2:0] Outstanding;
   logic       Error;

   int checks = 0;
   int failures = 0;

`ifdef READ_RETURN_ERRCHK_EN
   localparam logic ERR_EXP = 1'b1;
`else
   localparam logic ERR_EXP = 1'b0;
`endif

   read_return_demux #(
      .BITWIDTH(8),
      .DEPTH   (4)
   ) dut (
      .Clk        (Clk),
      .Rst_n      (Rst_n),
      .ReqValid   (ReqValid),
      .ReqSel     (ReqSel),
      .ReqReady   (ReqReady),
      .RdValid    (RdValid),
      .RdData     (RdData),
      .Out1Valid  (Out1Valid),
      .Out1Data   (Out1Data),
      .Out2Valid  (Out2Valid),
      .Out2Data   (Out2Data),
      .Outstanding(Outstanding),
      .Error      (Error)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input logic v1, input logic [7:0] d1,
                          input logic v2, input logic [7:0] d2, input logic [2:0] cnt);
      chk({tag, ".o1v"}, 32'(Out1Valid), 32'(v1));
      chk({tag, ".o1d"}, 32'(Out1Data), 32'(d1));
      chk({tag, ".o2v"}, 32'(Out2Valid), 32'(v2));
      chk({tag, ".o2d"}, 32'(Out2Data), 32'(d2));
      chk({tag, ".cnt"}, 32'(Outstanding), 32'(cnt));
   endtask

   initial begin
      // Reset and idle
      #1 Rst_n = 1'b0;
      #1;
      chk_out("rst", 1'b0, 8'h00, 1'b0, 8'h00, 3'd0);
      chk("rst.err", 32'(Error), 32'd0);
      chk("rst.rdy", 32'(ReqReady), 32'd1);
      tick();
      tick();
      Rst_n = 1'b1;
      tick();
      chk_out("idle", 1'b0, 8'h00, 1'b0, 8'h00, 3'd0);
      chk("idle.rdy", 32'(ReqReady), 32'd1);

      // Master 1 then master 2 reads, data A5 then 3C
      ReqValid = 1'b1; ReqSel = 1'b1;
      tick();
      ReqSel = 1'b0;
      tick();
      ReqValid = 1'b0;
      chk("two.cnt", 32'(Outstanding), 32'd2);
      RdValid = 1'b1; RdData = 8'hA5;
      tick();
      chk_out("rdA5", 1'b1, 8'hA5, 1'b0, 8'h00, 3'd1);
      RdData = 8'h3C;
      tick();
      chk_out("rd3C", 1'b0, 8'hA5, 1'b1, 8'h3C, 3'd0);
      RdValid = 1'b0;
      tick();
      chk_out("rdidle", 1'b0, 8'hA5, 1'b0, 8'h3C, 3'd0);
      chk("rdidle.err", 32'(Error), 32'd0);

      // Fill: tags 1,0,0,1
      ReqValid = 1'b1;
      ReqSel = 1'b1; tick();
      ReqSel = 1'b0; tick();
      ReqSel = 1'b0; tick();
      ReqSel = 1'b1; tick();
      chk("full.cnt", 32'(Outstanding), 32'd4);
      chk("full.rdy", 32'(ReqReady), 32'd0);
      chk("full.err", 32'(Error), 32'd0);
      // Fifth request is dropped
      ReqSel = 1'b0; tick();
      ReqValid = 1'b0;
      chk("ovf.cnt", 32'(Outstanding), 32'd4);
      chk("ovf.err", 32'(Error), 32'(ERR_EXP));

      // Pop head (master 1) leaving room
      RdValid = 1'b1; RdData = 8'h11;
      tick();
      chk_out("pop11", 1'b1, 8'h11, 1'b0, 8'h3C, 3'd3);
      chk("pop11.rdy", 32'(ReqReady), 32'd1);
      // Simultaneous push (master 1) and pop (head master 2)
      ReqValid = 1'b1; ReqSel = 1'b1; RdData = 8'h22;
      tick();
      ReqValid = 1'b0;
      chk_out("pp22", 1'b0, 8'h11, 1'b1, 8'h22, 3'd3);
      // Drain remaining tags 0,1,1 (last is the one pushed above)
      RdData = 8'h33; tick();
      chk_out("dr33", 1'b0, 8'h11, 1'b1, 8'h33, 3'd2);
      RdData = 8'h44; tick();
      chk_out("dr44", 1'b1, 8'h44, 1'b0, 8'h33, 3'd1);
      RdData = 8'h55; tick();
      chk_out("dr55", 1'b1, 8'h55, 1'b0, 8'h33, 3'd0);

      // Underflow: data with empty FIFO is dropped
      RdData = 8'hFF; tick();
      RdValid = 1'b0;
      chk_out("unf", 1'b0, 8'h55, 1'b0, 8'h33, 3'd0);
      chk("unf.err", 32'(Error), 32'(ERR_EXP));
      tick();
      chk("unf.sticky", 32'(Error), 32'(ERR_EXP));

      // Pop while empty with a push in the same cycle: no bypass
      ReqValid = 1'b1; ReqSel = 1'b1; RdValid = 1'b1; RdData = 8'h66;
      tick();
      ReqValid = 1'b0;
      chk_out("nobyp", 1'b0, 8'h55, 1'b0, 8'h33, 3'd1);
      RdData = 8'h77;
      tick();
      RdValid = 1'b0;
      chk_out("nobyp.pop", 1'b1, 8'h77, 1'b0, 8'h33, 3'd0);

      // Reset mid-stream with three outstanding reads
      ReqValid = 1'b1;
      ReqSel = 1'b1; tick();
      ReqSel = 1'b0; tick();
      ReqSel = 1'b1; tick();
      ReqValid = 1'b0;
      chk("mid.cnt", 32'(Outstanding), 32'd3);
      Rst_n = 1'b0;
      #1;
      chk_out("midrst", 1'b0, 8'h00, 1'b0, 8'h00, 3'd0);
      chk("midrst.err", 32'(Error), 32'd0);
      chk("midrst.rdy", 32'(ReqReady), 32'd1);
      #1 Rst_n = 1'b1;
      RdValid = 1'b1; RdData = 8'h99;
      tick();
      RdValid = 1'b0;
      chk_out("postrst", 1'b0, 8'h00, 1'b0, 8'h00, 3'd0);
      chk("postrst.err", 32'(Error), 32'(ERR_EXP));
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
